mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
Parametrised successor to the flat memory wrapper. It turns CPU load/store requests into a handshaked, region-decoded bus transaction.
- Regions: IROM (read-only), DRAM (read/write, byte enables) and an MMIO window with ack/timeout.
- Unmapped, misaligned and illegal accesses raise a fault instead of being silently dropped.
- Position: between the core's memory stage and the IROM, DRAM and peripheral fabric.

Parameters:
WIDTH, 32, data word width in bits; multiple of 8
ADDR_WIDTH, 32, byte-address width
IROM_BASE, 0x0000, IROM base byte address; aligned to IROM_SIZE
IROM_SIZE, 4096, IROM size in bytes; power of two
DRAM_BASE, 0x1000, DRAM base byte address; aligned to DRAM_SIZE
DRAM_SIZE, 4096, DRAM size in bytes; power of two
MMIO_BASE, 0x8000, MMIO base byte address
MMIO_SIZE, 256, MMIO size in bytes; power of two
MMIO_TIMEOUT, 15, cycles to wait for mmio_ack_i before faulting; >=1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_i  in  1  request valid
we_i  in  1  1 = store, 0 = load
addr_i  in  ADDR_WIDTH  byte address
wdata_i  in  WIDTH  store data
be_i  in  WIDTH/8  store byte enables
ready_o  out  1  request accepted when req_i && ready_o
rvalid_o  out  1  one-cycle response strobe, for both load and store
rdata_o  out  WIDTH  load data; 0 on store or fault
fault_o  out  1  qualifies rvalid_o: access faulted
irom_addr_o  out  ADDR_WIDTH  IROM word-aligned address
irom_rdata_i  in  WIDTH  IROM data, 1-cycle synchronous read
dram_we_o  out  WIDTH/8  DRAM per-byte write strobes
dram_addr_o  out  ADDR_WIDTH  DRAM address, region offset
dram_wdata_o  out  WIDTH  DRAM write data
dram_rdata_i  in  WIDTH  DRAM data, 1-cycle synchronous read
mmio_req_o  out  1  MMIO request, held until ack or timeout
mmio_we_o  out  1  MMIO write
mmio_addr_o  out  ADDR_WIDTH  MMIO region offset
mmio_wdata_o  out  WIDTH  MMIO write data
mmio_ack_i  in  1  MMIO completion; rdata valid in the same cycle
mmio_rdata_i  in  WIDTH  MMIO read data

Behaviour:
- Reset values: state IDLE. ready_o=1; rvalid_o=0; fault_o=0; rdata_o=0; dram_we_o=0; mmio_req_o=0; timeout counter=0. Reset mid-transaction aborts it with no response.
- Decode in the accept cycle, base/size match per region:
  - Fault if the address is misaligned (low log2(WIDTH/8) bits nonzero).
  - Fault on a store to IROM.
  - Fault if no region matches.
  - Fault when be_i==0 on a store.
- States: IDLE, MEM, MMIO, RESP.
- ready_o = (state==IDLE).
- IDLE, accept at cycle N:
  - IROM/DRAM: address driven combinationally in cycle N; dram_we_o = be_i for a DRAM store, only in cycle N. Go to MEM.
  - Fault: no downstream strobe. Go to RESP with fault flag set.
  - MMIO: latch we/offset/wdata, assert mmio_req_o from N+1, clear the counter. Go to MMIO.
- MEM (cycle N+1):
  - rvalid_o=1.
  - rdata_o = irom_rdata_i or dram_rdata_i, chosen by the region latched at N; 0 for stores.
  - Go to IDLE.
- MMIO:
  - mmio_ack_i=1: drop mmio_req_o, capture mmio_rdata_i (0 if write), go to RESP.
  - Otherwise increment the counter. When counter==MMIO_TIMEOUT-1 without ack, drop req, set fault, go to RESP.
  - An ack in the same cycle as the timeout wins: no fault.
- RESP: rvalid_o=1 for one cycle with the registered rdata and fault, then IDLE.
- Throughput: one access per 2 cycles for memory and fault paths; 2+wait cycles for MMIO.
- No new request is accepted while a response is pending.

Optional Feature:
MEM_FAULT_INFO_EN.
- Defined: adds outputs fault_addr_o (ADDR_WIDTH) and fault_cause_o (2 bits: 0 unmapped, 1 misaligned, 2 ROM write, 3 MMIO timeout; be_i==0 reports as 1). They are captured on each faulting response, hold until the next fault, and reset to 0.
- Undefined: ports absent; fault_o behaviour unchanged.

Decomposition:
- Shared package: bus state enum, region-select enum {REG_IROM, REG_DRAM, REG_MMIO, REG_NONE}, fault-cause codes, and the default base/size constants.
- One natural sub-module, mem_region_decode: combinational decode of address and we to region select, offset and fault cause.

Test Plan:
- Load addr 0x0004 (IROM) -> rvalid_o at N+1, rdata_o = IROM word 1, fault_o=0.
- Store 0xDEADBEEF to 0x1008 with be_i=4'b0011, then load 0x1008 -> only bytes 0-1 written; rdata_o low half = 0xBEEF, upper half unchanged.
- Store to 0x0010 and load from 0x4000 -> each gives rvalid_o=1, fault_o=1, dram_we_o=0; load from 0x1002 -> fault (misaligned).
- MMIO load 0x8004 with ack after 3 cycles, rdata 0x55 -> mmio_req_o high 3 cycles, rvalid_o in the cycle after ack, rdata_o=0x55.
- MMIO store with no ack, MMIO_TIMEOUT=15 -> mmio_req_o drops after 15 cycles, rvalid_o=1, fault_o=1.
- Assert rst while in MMIO -> all outputs return to reset values immediately; no rvalid_o; next request accepted normally.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and defaults for the region-decoded memory bus controller.
// Fault-cause codes are consumed only when MEM_FAULT_INFO_EN is defined.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_MMIO, S_RESP} bus_state_t;

  typedef enum logic [1:0] {REG_IROM, REG_DRAM, REG_MMIO, REG_NONE} region_t;

  localparam logic [1:0] CAUSE_UNMAPPED  = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
  localparam logic [1:0] CAUSE_ROM_WRITE = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

  localparam int unsigned DEF_IROM_BASE = 32'h0000_0000;
  localparam int unsigned DEF_IROM_SIZE = 4096;
  localparam int unsigned DEF_DRAM_BASE = 32'h0000_1000;
  localparam int unsigned DEF_DRAM_SIZE = 4096;
  localparam int unsigned DEF_MMIO_BASE = 32'h0000_8000;
  localparam int unsigned DEF_MMIO_SIZE = 256;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decode: region select, region offset and fault flag.
// The fault-cause output exists only when MEM_FAULT_INFO_EN is defined.
module mem_region_decode
  import mem_bus_ctrl_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned IROM_BASE  = DEF_IROM_BASE,
  parameter int unsigned IROM_SIZE  = DEF_IROM_SIZE,
  parameter int unsigned DRAM_BASE  = DEF_DRAM_BASE,
  parameter int unsigned DRAM_SIZE  = DEF_DRAM_SIZE,
  parameter int unsigned MMIO_BASE  = DEF_MMIO_BASE,
  parameter int unsigned MMIO_SIZE  = DEF_MMIO_SIZE
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [WIDTH/8-1:0]    i_be,
  output region_t               o_region,
  output logic [ADDR_WIDTH-1:0] o_offset,
  output logic                  o_fault
`ifdef MEM_FAULT_INFO_EN
  ,
  output logic [1:0]            o_cause
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WIDTH/8 - 1);
  localparam logic [ADDR_WIDTH-1:0] IROM_MASK  = ADDR_WIDTH'(IROM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAM_MASK  = ADDR_WIDTH'(DRAM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] MMIO_MASK  = ADDR_WIDTH'(MMIO_SIZE - 1);

  logic w_misaligned;
  logic w_hit_irom;
  logic w_hit_dram;
  logic w_hit_mmio;

  assign w_misaligned = (i_addr & ALIGN_MASK) != '0;
  assign w_hit_irom   = (i_addr & ~IROM_MASK) == ADDR_WIDTH'(IROM_BASE);
  assign w_hit_dram   = (i_addr & ~DRAM_MASK) == ADDR_WIDTH'(DRAM_BASE);
  assign w_hit_mmio   = (i_addr & ~MMIO_MASK) == ADDR_WIDTH'(MMIO_BASE);

  always_comb begin
    o_region = REG_NONE;
    o_offset = '0;
    if (w_hit_irom) begin
      o_region = REG_IROM;
      o_offset = i_addr & IROM_MASK;
    end else if (w_hit_dram) begin
      o_region = REG_DRAM;
      o_offset = i_addr & DRAM_MASK;
    end else if (w_hit_mmio) begin
      o_region = REG_MMIO;
      o_offset = i_addr & MMIO_MASK;
    end
  end

  assign o_fault = w_misaligned || (o_region == REG_NONE) ||
                   (i_we && ((o_region == REG_IROM) || (i_be == '0)));

`ifdef MEM_FAULT_INFO_EN
  // An empty byte-enable store is reported with the misaligned code.
  always_comb begin
    if (w_misaligned)                         o_cause = CAUSE_MISALIGN;
    else if (o_region == REG_NONE)            o_cause = CAUSE_UNMAPPED;
    else if (i_we && o_region == REG_IROM)    o_cause = CAUSE_ROM_WRITE;
    else                                      o_cause = CAUSE_MISALIGN;
  end
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU load/store to IROM / DRAM / MMIO bus controller with fault reporting.
// Define MEM_FAULT_INFO_EN to add fault_addr_o / fault_cause_o.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int unsigned IROM_BASE    = DEF_IROM_BASE,
  parameter int unsigned IROM_SIZE    = DEF_IROM_SIZE,
  parameter int unsigned DRAM_BASE    = DEF_DRAM_BASE,
  parameter int unsigned DRAM_SIZE    = DEF_DRAM_SIZE,
  parameter int unsigned MMIO_BASE    = DEF_MMIO_BASE,
  parameter int unsigned MMIO_SIZE    = DEF_MMIO_SIZE,
  parameter int          MMIO_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    be_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] irom_addr_o,
  input  logic [WIDTH-1:0]      irom_rdata_i,
  output logic [WIDTH/8-1:0]    dram_we_o,
  output logic [ADDR_WIDTH-1:0] dram_addr_o,
  output logic [WIDTH-1:0]      dram_wdata_o,
  input  logic [WIDTH-1:0]      dram_rdata_i,
  output logic                  mmio_req_o,
  output logic                  mmio_we_o,
  output logic [ADDR_WIDTH-1:0] mmio_addr_o,
  output logic [WIDTH-1:0]      mmio_wdata_o,
  input  logic                  mmio_ack_i,
  input  logic [WIDTH-1:0]      mmio_rdata_i
`ifdef MEM_FAULT_INFO_EN
  ,
  output logic [ADDR_WIDTH-1:0] fault_addr_o,
  output logic [1:0]            fault_cause_o
`endif
);

  localparam int CNT_W = $clog2(MMIO_TIMEOUT + 1);

  bus_state_t            r_state, w_next;
  region_t               w_region, r_region;
  logic [ADDR_WIDTH-1:0] w_offset, r_mmio_addr;
  logic                  w_fault, w_accept, w_timeout, w_mmio_done;
  logic                  r_we, r_fault;
  logic [WIDTH-1:0]      r_mmio_wdata, r_rdata;
  logic [CNT_W-1:0]      r_cnt;
`ifdef MEM_FAULT_INFO_EN
  logic [1:0]            w_cause;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_fault_addr;
  logic [1:0]            r_fault_cause;
`endif

  mem_region_decode #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .IROM_BASE(IROM_BASE), .IROM_SIZE(IROM_SIZE),
    .DRAM_BASE(DRAM_BASE), .DRAM_SIZE(DRAM_SIZE),
    .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE)
  ) u_decode (
    .i_addr   (addr_i),
    .i_we     (we_i),
    .i_be     (be_i),
    .o_region (w_region),
    .o_offset (w_offset),
    .o_fault  (w_fault)
`ifdef MEM_FAULT_INFO_EN
    ,
    .o_cause  (w_cause)
`endif
  );

  assign w_accept    = req_i && (r_state == S_IDLE);
  assign w_timeout   = (r_cnt == CNT_W'(MMIO_TIMEOUT - 1));
  assign w_mmio_done = (r_state == S_MMIO) && (mmio_ack_i || w_timeout);

  assign irom_addr_o  = addr_i & ~ADDR_WIDTH'(WIDTH/8 - 1);
  assign dram_addr_o  = w_offset;
  assign dram_wdata_o = wdata_i;
  assign mmio_we_o    = r_we;
  assign mmio_addr_o  = r_mmio_addr;
  assign mmio_wdata_o = r_mmio_wdata;

  always_comb begin
    w_next     = r_state;
    ready_o    = 1'b0;
    rvalid_o   = 1'b0;
    fault_o    = 1'b0;
    rdata_o    = '0;
    dram_we_o  = '0;
    mmio_req_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          if (w_fault) begin
            w_next = S_RESP;
          end else if (w_region == REG_MMIO) begin
            w_next = S_MMIO;
          end else begin
            w_next = S_MEM;
            if (we_i && w_region == REG_DRAM) dram_we_o = be_i;
          end
        end
      end
      // Synchronous memories answer in the cycle after the address was driven.
      S_MEM: begin
        rvalid_o = 1'b1;
        if (!r_we) rdata_o = (r_region == REG_IROM) ? irom_rdata_i : dram_rdata_i;
        w_next = S_IDLE;
      end
      S_MMIO: begin
        mmio_req_o = 1'b1;
        if (mmio_ack_i || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        rvalid_o = 1'b1;
        rdata_o  = r_rdata;
        fault_o  = r_fault;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fault <= 1'b0;
`ifdef MEM_FAULT_INFO_EN
      r_fault_addr  <= '0;
      r_fault_cause <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_fault <= w_fault;
      end else if (r_state == S_MMIO) begin
        // An ack arriving on the last wait cycle still completes cleanly.
        if (mmio_ack_i)     r_fault <= 1'b0;
        else if (w_timeout) r_fault <= 1'b1;
        else                r_cnt   <= r_cnt + 1'b1;
      end
`ifdef MEM_FAULT_INFO_EN
      if (w_accept && w_fault) begin
        r_fault_addr  <= addr_i;
        r_fault_cause <= w_cause;
      end else if (r_state == S_MMIO && !mmio_ack_i && w_timeout) begin
        r_fault_addr  <= r_addr;
        r_fault_cause <= CAUSE_TIMEOUT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_region     <= w_region;
      r_we         <= we_i;
      r_mmio_addr  <= w_offset;
      r_mmio_wdata <= wdata_i;
`ifdef MEM_FAULT_INFO_EN
      r_addr       <= addr_i;
`endif
    end
    if (w_accept && w_fault)
      r_rdata <= '0;
    else if (w_mmio_done)
      r_rdata <= (mmio_ack_i && !r_we) ? mmio_rdata_i : '0;
  end

`ifdef MEM_FAULT_INFO_EN
  assign fault_addr_o  = r_fault_addr;
  assign fault_cause_o = r_fault_cause;
`endif

endmodule
